// File: rtl/btn_pkg.sv
// Shared definitions for the tempo push-button conditioner: channel indices,
// debounce FSM encoding and the millisecond-to-cycle conversion helper.
// Optional feature macro (see btn_debounce): BTN_AUTOREPEAT_EN.
package btn_pkg;

    // Channel index of each button within the 4-bit raw/level buses.
    localparam int BTN_P1  = 0;
    localparam int BTN_P5  = 1;
    localparam int BTN_M1  = 2;
    localparam int BTN_M5  = 3;
    localparam int NUM_BTN = 4;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Convert a duration in milliseconds to a number of clock cycles.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, polarity normalisation, stable-time
// debounce FSM and a single-cycle press strobe. With BTN_AUTOREPEAT_EN
// defined, a held button also emits repeat strobes (first after the repeat
// delay, then at the repeat rate); otherwise no repeat logic exists.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_raw,
    output logic o_strobe,
    output logic o_level
);

    localparam int unsigned    DB_CNT  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int             CNT_W   = $clog2(DB_CNT + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);
    // Raw pin level of a released button.
    localparam logic           RELEASED = BTN_ACTIVE_LOW;

    // A debounce window shorter than two cycles cannot distinguish a bounce.
    if (DB_CNT < 2) begin : g_bad_db_cnt
        $error("btn_debounce: DB_CNT must be at least 2");
    end

    // Repeat timings of zero would make the repeat counter compare meaningless.
    if (REPEAT_DELAY_MS == 0 || REPEAT_RATE_MS == 0) begin : g_bad_repeat
        $error("btn_debounce: repeat delay and rate must be non-zero");
    end

    logic                 sync_q1;
    logic                 sync_q2;
    logic                 pressed;
    btn_state_e           state_q;
    btn_state_e           state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 press_strobe;

    // Two-stage synchroniser; reset loads the released level so no false
    // press is seen while the chain refills after reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge value of its source (sync_q2 gets the
        // old sync_q1, giving a true two-stage chain).
        if (!i_reset) begin
            sync_q1 <= RELEASED;
            sync_q2 <= RELEASED;
        end else begin
            sync_q1 <= i_btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // 1 = pressed, independent of pin polarity.
    assign pressed = sync_q2 ^ RELEASED;

    // FSM state and stable-time counter registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a level change is accepted only after DB_CNT
    // consecutive cycles of the new level; the counter never passes DB_LAST.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_strobe = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    cnt_d   = '0;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q >= DB_LAST) begin
                    cnt_d        = '0;
                    state_d      = HELD;
                    press_strobe = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    // Release was a bounce: back to held, no new press.
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q >= DB_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Debounced level is high from HELD entry until the release is accepted.
    assign o_level = (state_q == HELD) || (state_q == RELEASE_WAIT);

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_DELAY = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int unsigned RPT_RATE  = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
    localparam int unsigned RPT_MAX   = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int          RPT_W     = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_first_q;  // still waiting for the initial delay
    logic [RPT_W-1:0] rpt_last;
    logic             rpt_fire;

    // Repeat fires while the button stays held and the counter hits the
    // current interval (delay before the first repeat, rate afterwards).
    always_comb begin
        rpt_last = rpt_first_q ? RPT_W'(RPT_DELAY - 1) : RPT_W'(RPT_RATE - 1);
        rpt_fire = (state_q == HELD) && pressed && (rpt_cnt_q >= rpt_last);
    end

    // Repeat counter runs only in HELD; anything else restarts the delay.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else if ((state_q != HELD) || !pressed) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
        end
    end

    assign o_strobe = press_strobe | rpt_fire;
`else
    assign o_strobe = press_strobe;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Tempo push-button conditioner: four btn_debounce channels feeding a
// fixed-priority arbiter (-5 > -1 > +5 > +1) with one pending bit per
// channel, so the registered pulse outputs are one-hot or zero every cycle.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while held).
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [3:0]   i_btn_raw,
    output logic         o_btn_plus_1,
    output logic         o_btn_plus_5,
    output logic         o_btn_minus_1,
    output logic         o_btn_minus_5,
    output logic [3:0]   o_btn_level
);

    logic [NUM_BTN-1:0] strobe;
    logic [NUM_BTN-1:0] request;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] pending_q;
    logic [NUM_BTN-1:0] pending_d;
    logic [NUM_BTN-1:0] pulse_q;

    for (genvar ch = 0; ch < NUM_BTN; ch++) begin : g_ch
        btn_debounce #(
            .CLK_HZ          (CLK_HZ),
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_debounce (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_btn_raw (i_btn_raw[ch]),
            .o_strobe  (strobe[ch]),
            .o_level   (o_btn_level[ch])
        );
    end

    // Fixed-priority pick among new strobes and pending requests; losers
    // stay pending, and a repeat strobe on an already pending channel merges
    // into the single pending bit (depth 1).
    always_comb begin
        request = strobe | pending_q;
        grant   = '0;
        if (request[BTN_M5]) begin
            grant[BTN_M5] = 1'b1;
        end else if (request[BTN_M1]) begin
            grant[BTN_M1] = 1'b1;
        end else if (request[BTN_P5]) begin
            grant[BTN_P5] = 1'b1;
        end else if (request[BTN_P1]) begin
            grant[BTN_P1] = 1'b1;
        end
        pending_d = request & ~grant;
    end

    // Pending bits and registered one-hot pulse outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pending_q <= '0;
            pulse_q   <= '0;
        end else begin
            pending_q <= pending_d;
            pulse_q   <= grant;
        end
    end

    assign o_btn_plus_1  = pulse_q[BTN_P1];
    assign o_btn_plus_5  = pulse_q[BTN_P5];
    assign o_btn_minus_1 = pulse_q[BTN_M1];
    assign o_btn_minus_5 = pulse_q[BTN_M5];

endmodule
